// File: rtl/ppu_rowram_pingpong.sv
// ---------------------------------------------------------------------------
// ppu_rowram_pingpong
//
// Double-buffered row RAM between the PPU pixel engine and the HDMI output.
// The PPU streams one row of palette indices into the back bank. The HDMI
// side reads the front bank at arbitrary addresses with one cycle of latency.
// Bank roles exchange on every rowram_swap pulse.
//
// A swap that arrives while a row is still being filled is an underrun. It is
// counted in a saturating counter. The banks still exchange, and filling
// restarts at address 0 with the newly sampled row number.
//
// Optional feature (define ROWRAM_UNDERRUN_BLANK_EN):
//   Each bank records how many pixels it holds at the moment it becomes front.
//   Reads at or beyond that count return 0 (transparent) instead of stale
//   pixels left over from an older row. Without the macro, no count is kept
//   and a partially filled row shows stale data past its last written pixel.
//
// Ports
//   clk             in   block clock
//   rst_n           in   asynchronous active-low reset
//   rowram_swap     in   pulse: swap banks, start filling the new back bank
//   vblank_start    in   pulse: abort any fill, go IDLE (the swap toggle
//                        still applies)
//   vblank_end_soon in   pulse: start filling the back bank without a swap
//   next_row        in   row index sampled when a fill starts
//   fill_row        out  row currently being filled
//   pix_valid       in   PPU pixel valid
//   pix_data        in   PPU pixel value (write address is implicit)
//   pix_ready       out  high only in FILL
//   row_done        out  one-cycle pulse after the last pixel of a row
//   rd_addr         in   HDMI read address into the front bank
//   rd_data         out  front-bank data, one cycle after rd_addr
//   underrun_cnt    out  saturating count of swaps taken during FILL
// ---------------------------------------------------------------------------
module ppu_rowram_pingpong #(
    parameter int ROW_PIXELS = 320,
    parameter int PIX_W      = 10,
    parameter int UNDER_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rowram_swap,
    input  logic               vblank_start,
    input  logic               vblank_end_soon,
    input  logic [7:0]         next_row,
    output logic [7:0]         fill_row,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic               row_done,
    input  logic [8:0]         rd_addr,
    output logic [PIX_W-1:0]   rd_data,
    output logic [UNDER_W-1:0] underrun_cnt
);

    // Pixel counts run from 0 to 512, so they need 10 bits.
    localparam int CNT_W = 10;
    localparam int IDX_W = $clog2(2 * ROW_PIXELS);
    localparam logic [8:0]       LAST_PIX = 9'(ROW_PIXELS - 1);
    localparam logic [CNT_W-1:0] ROW_LEN  = CNT_W'(ROW_PIXELS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 front_q, front_d;
    logic [8:0]           wr_cnt_q, wr_cnt_d;
    logic [7:0]           fill_row_q, fill_row_d;
    logic                 row_done_q, row_done_d;
    logic [UNDER_W-1:0]   under_q, under_d;

    logic                 wr_en;
    logic                 last_wr;
    logic                 start_fill;

    // Both banks share one array. Bank 1 occupies the upper ROW_PIXELS
    // entries, so a single simple dual-port RAM is inferred.
    logic [PIX_W-1:0]     mem [2*ROW_PIXELS];
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_hit;
    logic [PIX_W-1:0]     rd_raw_q;
    logic                 rd_ok_q;

    // -----------------------------------------------------------------------
    // Write side
    // -----------------------------------------------------------------------
    // vblank_start freezes both the bank and the counter. A pixel offered in
    // that same cycle is therefore dropped, even though pix_ready is still high.
    assign wr_en   = pix_valid && (state_q == ST_FILL) && !vblank_start;
    assign last_wr = wr_en && (wr_cnt_q == LAST_PIX);

    // Writes always go to the bank that is back before this edge. A pixel
    // that lands in the swap cycle therefore completes the old row.
    assign wr_idx = front_q ? IDX_W'(wr_cnt_q)
                            : IDX_W'(ROW_PIXELS) + IDX_W'(wr_cnt_q);

    // A fill restarts on any swap, and on vblank_end_soon from IDLE only.
    // vblank_start overrides both.
    assign start_fill = !vblank_start &&
                        (rowram_swap ||
                         (vblank_end_soon && (state_q == ST_IDLE)));

    // NOTE: every signal written here gets a default first. Then no path
    // leaves a value unassigned, and no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        front_d    = front_q;
        wr_cnt_d   = wr_cnt_q;
        fill_row_d = fill_row_q;
        row_done_d = 1'b0;
        under_d    = under_q;

        if (wr_en) begin
            if (last_wr) begin
                state_d    = ST_DONE;
                row_done_d = 1'b1;
                wr_cnt_d   = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + 9'd1;
            end
        end

        if (rowram_swap) begin
            front_d = ~front_q;
            // A row that completes in the swap cycle is not an underrun.
            if ((state_q == ST_FILL) && !last_wr && (under_q != '1)) begin
                under_d = under_q + UNDER_W'(1);
            end
        end

        if (vblank_start) begin
            state_d = ST_IDLE;
        end else if (start_fill) begin
            state_d    = ST_FILL;
            fill_row_d = next_row;
            wr_cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            front_q    <= 1'b0;
            wr_cnt_q   <= '0;
            fill_row_q <= '0;
            row_done_q <= 1'b0;
            under_q    <= '0;
        end else begin
            state_q    <= state_d;
            front_q    <= front_d;
            wr_cnt_q   <= wr_cnt_d;
            fill_row_q <= fill_row_d;
            row_done_q <= row_done_d;
            under_q    <= under_d;
        end
    end

    // NOTE: the RAM array has no reset. Resetting it would block block-RAM
    // inference, and its contents are undefined after reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= pix_data;
        end
    end

    // -----------------------------------------------------------------------
    // Optional per-bank fill count for blanking incomplete rows
    // -----------------------------------------------------------------------
`ifdef ROWRAM_UNDERRUN_BLANK_EN
    logic [CNT_W-1:0] front_cnt_q, front_cnt_d;
    logic [CNT_W-1:0] back_cnt_q, back_cnt_d;
    logic [CNT_W-1:0] back_after_wr;

    always_comb begin
        back_after_wr = wr_en ? ({1'b0, wr_cnt_q} + CNT_W'(1)) : back_cnt_q;
        front_cnt_d   = front_cnt_q;
        back_cnt_d    = back_after_wr;
        if (rowram_swap) begin
            // The outgoing back bank becomes front together with its count.
            // The old front becomes back and keeps its own count until a
            // fill restarts it.
            front_cnt_d = back_after_wr;
            back_cnt_d  = front_cnt_q;
        end
        if (start_fill) begin
            back_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_cnt_q <= '0;
            back_cnt_q  <= '0;
        end else begin
            front_cnt_q <= front_cnt_d;
            back_cnt_q  <= back_cnt_d;
        end
    end

    assign rd_hit = ({1'b0, rd_addr} < ROW_LEN) && ({1'b0, rd_addr} < front_cnt_q);
`else
    assign rd_hit = ({1'b0, rd_addr} < ROW_LEN);
`endif

    // -----------------------------------------------------------------------
    // Read side
    // -----------------------------------------------------------------------
    // front_q is sampled before the edge, so a read issued in the swap cycle
    // still returns data from the pre-swap front bank.
    assign rd_idx = front_q ? IDX_W'(ROW_PIXELS) + IDX_W'(rd_addr)
                            : IDX_W'(rd_addr);

    // The raw data register carries no reset, so it maps onto the RAM output
    // register. A separate reset flag forces 0 after reset and for misses.
    always_ff @(posedge clk) begin
        if (rd_hit) begin
            rd_raw_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= rd_hit;
        end
    end

    assign rd_data      = rd_ok_q ? rd_raw_q : '0;
    assign pix_ready    = (state_q == ST_FILL);
    assign row_done     = row_done_q;
    assign fill_row     = fill_row_q;
    assign underrun_cnt = under_q;

endmodule

// File: tb/tb_ppu_rowram_pingpong.sv
// ---------------------------------------------------------------------------
// tb_ppu_rowram_pingpong
//
// Self-checking bench for ppu_rowram_pingpong. Inputs change 1 time unit
// after each rising edge, and outputs are sampled at that same point. Every
// read expectation is pushed to a scoreboard queue when rd_addr is driven,
// then popped and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_ppu_rowram_pingpong;

    localparam int RP = 320;
    localparam int PW = 10;
    localparam int UW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rowram_swap = 1'b0;
    logic          vblank_start = 1'b0;
    logic          vblank_end_soon = 1'b0;
    logic [7:0]    next_row = '0;
    logic [7:0]    fill_row;
    logic          pix_valid = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_ready;
    logic          row_done;
    logic [8:0]    rd_addr = '0;
    logic [PW-1:0] rd_data;
    logic [UW-1:0] underrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [8:0]    addr;
        logic [PW-1:0] exp;
        string         name;
    } rd_vec_t;

    typedef struct {
        logic [PW-1:0] exp;
        string         name;
    } sb_t;

    sb_t     sb_q[$];
    rd_vec_t vecs[6];

    ppu_rowram_pingpong #(
        .ROW_PIXELS(RP),
        .PIX_W     (PW),
        .UNDER_W   (UW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rowram_swap    (rowram_swap),
        .vblank_start   (vblank_start),
        .vblank_end_soon(vblank_end_soon),
        .next_row       (next_row),
        .fill_row       (fill_row),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_ready      (pix_ready),
        .row_done       (row_done),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .underrun_cnt   (underrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop();
        sb_t s;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got no entry required one");
        end else begin
            s = sb_q.pop_front();
            check(s.name, 32'(rd_data), 32'(s.exp));
        end
    endtask

    // Drive one read address and compare the result one cycle later.
    task automatic rd_expect(input logic [8:0] a, input logic [PW-1:0] e, input string nm);
        sb_t s;
        s.exp  = e;
        s.name = nm;
        rd_addr = a;
        sb_q.push_back(s);
        tick();
        sb_pop();
    endtask

    task automatic pulse(input logic sw, input logic vbs, input logic ves, input logic [7:0] row);
        rowram_swap     = sw;
        vblank_start    = vbs;
        vblank_end_soon = ves;
        next_row        = row;
        tick();
        rowram_swap     = 1'b0;
        vblank_start    = 1'b0;
        vblank_end_soon = 1'b0;
    endtask

    // Stream n back-to-back pixels with values base + dir*i.
    task automatic feed(input int n, input int base, input int dir);
        pix_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_data = PW'(base + dir * i);
            tick();
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{9'd7,   10'd7,   "rd7_full_row"};
        vecs[1] = '{9'd0,   10'd0,   "rd0_full_row"};
        vecs[2] = '{9'd319, 10'd319, "rd319_last_pixel"};
        vecs[3] = '{9'd100, 10'd100, "rd100_full_row"};
        vecs[4] = '{9'd320, 10'd0,   "rd320_out_of_range"};
        vecs[5] = '{9'd511, 10'd0,   "rd511_out_of_range"};

        // ---------------- reset and idle ----------------
        repeat (3) tick();
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_underrun", 32'(underrun_cnt), 0);
        check("rst_fill_row", 32'(fill_row), 0);
        check("rst_row_done", 32'(row_done), 0);
        rst_n = 1'b1;
        tick();
        rd_expect(9'd400, '0, "idle_rd_out_of_range");
        check("idle_pix_ready", 32'(pix_ready), 0);

        // ---------------- full row via vblank_end_soon ----------------
        pulse(1'b0, 1'b0, 1'b1, 8'd5);
        check("ves_fill_row", 32'(fill_row), 5);
        check("ves_pix_ready", 32'(pix_ready), 1);
        feed(RP, 0, 1);
        check("full_row_done_pulse", 32'(row_done), 1);
        check("full_done_ready_low", 32'(pix_ready), 0);
        tick();
        check("full_row_done_clear", 32'(row_done), 0);
        pulse(1'b0, 1'b0, 1'b1, 8'd9);
        check("done_ignores_ves_ready", 32'(pix_ready), 0);
        check("done_ignores_ves_row", 32'(fill_row), 5);
        pulse(1'b1, 1'b0, 1'b0, 8'd6);
        check("swap_fill_row", 32'(fill_row), 6);
        check("swap_pix_ready", 32'(pix_ready), 1);
        check("swap_no_underrun", 32'(underrun_cnt), 0);
        for (int i = 0; i < 6; i++) begin
            rd_expect(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // ---------------- underrun after 100 pixels ----------------
        feed(100, 0, 1);
        pulse(1'b1, 1'b0, 1'b0, 8'd7);
        check("underrun_cnt_1", 32'(underrun_cnt), 1);
        check("underrun_fill_row", 32'(fill_row), 7);
        check("underrun_ready", 32'(pix_ready), 1);
        rd_expect(9'd50, 10'd50, "underrun_rd50");
        rd_expect(9'd99, 10'd99, "underrun_rd99");
`ifdef ROWRAM_UNDERRUN_BLANK_EN
        rd_expect(9'd150, 10'd0, "underrun_rd150_blank");
`endif

        // ---------------- last pixel coincides with swap ----------------
        feed(RP - 1, RP - 1, -1);
        pix_valid   = 1'b1;
        pix_data    = '0;
        rowram_swap = 1'b1;
        next_row    = 8'd8;
        tick();
        pix_valid   = 1'b0;
        rowram_swap = 1'b0;
        check("coinc_row_done", 32'(row_done), 1);
        check("coinc_no_underrun", 32'(underrun_cnt), 1);
        check("coinc_fill_row", 32'(fill_row), 8);
        check("coinc_ready", 32'(pix_ready), 1);
        rd_expect(9'd0, 10'd319, "coinc_rd0_restart");
        check("coinc_row_done_clear", 32'(row_done), 0);
        rd_expect(9'd7, 10'd312, "coinc_rd7");
        rd_expect(9'd319, 10'd0, "coinc_rd319_last");

        // ---------------- vblank_start mid-fill ----------------
        pix_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pix_data = PW'(700 + i);
            tick();
        end
        pix_data     = PW'(900);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        check("vbs_ready_drop", 32'(pix_ready), 0);
        for (int i = 0; i < 5; i++) begin
            pix_data = PW'(901 + i);
            tick();
            check("vbs_ready_held_low", 32'(pix_ready), 0);
        end
        pix_valid = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 8'd9);
        check("vbs_swap_fill_row", 32'(fill_row), 9);
        check("vbs_swap_ready", 32'(pix_ready), 1);
        check("vbs_swap_underrun", 32'(underrun_cnt), 1);
        rd_expect(9'd0, 10'd700, "vbs_rd0");
        rd_expect(9'd9, 10'd709, "vbs_rd9");
`ifdef ROWRAM_UNDERRUN_BLANK_EN
        rd_expect(9'd11, 10'd0, "vbs_rd11_blank");
        rd_expect(9'd50, 10'd0, "vbs_rd50_blank");
`else
        rd_expect(9'd11, 10'd11, "vbs_rd11_stale");
        rd_expect(9'd50, 10'd50, "vbs_rd50_stale");
`endif

        // ---------------- asynchronous reset mid-fill ----------------
        rd_addr   = 9'd3;
        pix_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            pix_data = PW'(i);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_pix_ready", 32'(pix_ready), 0);
        check("arst_fill_row", 32'(fill_row), 0);
        check("arst_underrun", 32'(underrun_cnt), 0);
        check("arst_row_done", 32'(row_done), 0);
        check("arst_rd_data", 32'(rd_data), 0);
        pix_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulse(1'b0, 1'b0, 1'b1, 8'd3);
        check("post_rst_fill_row", 32'(fill_row), 3);
        feed(5, 40, 1);
        pulse(1'b1, 1'b0, 1'b0, 8'd4);
        check("post_rst_underrun", 32'(underrun_cnt), 1);
        rd_expect(9'd0, 10'd40, "post_rst_rd0");
        rd_expect(9'd4, 10'd44, "post_rst_rd4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
